// File: rtl/sum_accum16.sv
// ---------------------------------------------------------------------------
// sum_accum16 - frame accumulator behind the 16-bit ripple-carry adder.
//
// Sums a programmed number of 17-bit adder results ({carry-out, sum}) into an
// ACC_W-bit register. It then presents the total, the beat count and a sticky
// overflow flag on a valid/ready output.
//
// Build option:
//   SUM_ACCUM16_SAT_EN  defined   : the accumulator clamps to all-ones on overflow
//                       undefined : the accumulator wraps modulo 2^ACC_W
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a frame (sampled in IDLE only)
//   frame_len  beats per frame, latched on start
//   in_valid   upstream beat valid
//   in_ready   beat accepted this cycle when in_valid is also high
//   in_sum     adder sum
//   in_cout    adder carry-out
//   out_valid  frame result available
//   out_ready  downstream takes the result
//   out_acc    frame total
//   out_cnt    beats accumulated
//   out_ovf    accumulator carried out of ACC_W during the frame
//   busy       state is not IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; last frame's result held on outputs
// ACC   | accepting beats until len_q beats are summed
// DONE  | result valid, waiting for out_ready
// ---------------------------------------------------------------------------
module sum_accum16 #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] frame_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_sum,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] opnd;
    logic [ACC_W:0]   tmp;
    logic             beat;

    assign opnd = ACC_W'({in_cout, in_sum});
    assign tmp  = {1'b0, acc_q} + {1'b0, opnd};
    assign beat = in_valid && (state_q == ACC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = frame_len;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (frame_len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (beat) begin
                    if (tmp[ACC_W]) begin
                        ovf_d = 1'b1;
                    end
`ifdef SUM_ACCUM16_SAT_EN
                    // Once saturated, any further non-zero beat carries out again,
                    // so the clamp holds for the rest of the frame.
                    acc_d = tmp[ACC_W] ? '1 : tmp[ACC_W-1:0];
`else
                    acc_d = tmp[ACC_W-1:0];
`endif
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_acc   = acc_q;
    assign out_cnt   = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sum_accum16.sv
// Directed bench for sum_accum16 with default parameters (ACC_W=24, CNT_W=8).
module tb_sum_accum16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  frame_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_sum = '0;
    logic        in_cout = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_acc;
    logic [7:0]  out_cnt;
    logic        out_ovf;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sum_accum16 #(.ACC_W(24), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .frame_len (frame_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] len);
        start     = 1'b1;
        frame_len = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic beat(input logic cout, input logic [15:0] sum);
        in_valid = 1'b1;
        in_cout  = cout;
        in_sum   = sum;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_fall"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acc", 32'(out_acc), 32'd0);
        chk("rst_cnt", 32'(out_cnt), 32'd0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // basic frame
        do_start(8'd3);
        chk("basic_ready", 32'(in_ready), 32'd1);
        chk("basic_busy", 32'(busy), 32'd1);
        beat(1'b0, 16'hFFFF);
        beat(1'b1, 16'h0000);
        chk("basic_not_done", 32'(out_valid), 32'd0);
        beat(1'b0, 16'h0001);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_ready_low", 32'(in_ready), 32'd0);
        chk("basic_acc", 32'(out_acc), 32'h020000);
        chk("basic_cnt", 32'(out_cnt), 32'd3);
        chk("basic_ovf", 32'(out_ovf), 32'd0);
        release_result("basic");
        chk("basic_hold_acc", 32'(out_acc), 32'h020000);

        // overflow frame: 129 * 0x1FFFF = 0x101FF7F
        do_start(8'd129);
        for (int i = 0; i < 129; i++) beat(1'b1, 16'hFFFF);
        chk("ovf_valid", 32'(out_valid), 32'd1);
        chk("ovf_flag", 32'(out_ovf), 32'd1);
        chk("ovf_cnt", 32'(out_cnt), 32'd129);
`ifdef SUM_ACCUM16_SAT_EN
        chk("ovf_acc", 32'(out_acc), 32'hFFFFFF);
`else
        chk("ovf_acc", 32'(out_acc), 32'h01FF7F);
`endif
        release_result("ovf");

        // upstream back-pressure: valid on alternate cycles
        do_start(8'd4);
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_cout  = 1'b0;
            in_sum   = 16'h0010;
            if (i == 6) chk("bp_last_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_acc", 32'(out_acc), 32'h40);
        chk("bp_cnt", 32'(out_cnt), 32'd4);
        chk("bp_ovf_cleared", 32'(out_ovf), 32'd0);

        // downstream back-pressure with upstream still offering beats
        in_valid = 1'b1;
        in_sum   = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_acc", 32'(out_acc), 32'h40);
            chk("hold_cnt", 32'(out_cnt), 32'd4);
        end
        release_result("hold");

        // zero length, in_valid still high in IDLE
        do_start(8'd0);
        chk("zero_valid", 32'(out_valid), 32'd1);
        chk("zero_ready", 32'(in_ready), 32'd0);
        chk("zero_acc", 32'(out_acc), 32'd0);
        chk("zero_cnt", 32'(out_cnt), 32'd0);
        chk("zero_ovf", 32'(out_ovf), 32'd0);
        in_valid = 1'b0;
        release_result("zero");

        // reset mid-frame
        do_start(8'd5);
        beat(1'b0, 16'h0010);
        beat(1'b0, 16'h0010);
        chk("mid_partial", 32'(out_acc), 32'h20);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ready", 32'(in_ready), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_acc", 32'(out_acc), 32'd0);
        chk("mid_cnt", 32'(out_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mid_no_valid", 32'(out_valid), 32'd0);
        do_start(8'd1);
        beat(1'b0, 16'h0005);
        chk("mid_new_valid", 32'(out_valid), 32'd1);
        chk("mid_new_acc", 32'(out_acc), 32'd5);
        chk("mid_new_cnt", 32'(out_cnt), 32'd1);
        release_result("mid");

        // start ignored in ACC and DONE
        do_start(8'd2);
        start     = 1'b1;
        frame_len = 8'd9;
        beat(1'b0, 16'h0003);
        start     = 1'b0;
        chk("ign_still_acc", 32'(in_ready), 32'd1);
        beat(1'b0, 16'h0004);
        chk("ign_valid", 32'(out_valid), 32'd1);
        start     = 1'b1;
        frame_len = 8'd1;
        tick();
        start     = 1'b0;
        chk("ign_done_valid", 32'(out_valid), 32'd1);
        chk("ign_acc", 32'(out_acc), 32'd7);
        chk("ign_cnt", 32'(out_cnt), 32'd2);
        release_result("ign");
        tick();
        chk("ign_no_extra", 32'(busy), 32'd0);
        chk("ign_no_extra_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sum_accum16.md
# sum_accum16

Frame accumulator placed directly downstream of the 16-bit ripple-carry adder. Each accepted beat is the adder result taken as a 17-bit unsigned value {carry-out, sum}. The block adds a software-programmed number of beats into a wide register and presents the total, beat count and sticky overflow flag on a valid/ready output. It gives the datapath a multi-cycle reduction stage, turning single-cycle adder results into per-frame totals.

## Interface
Parameters:
- ACC_W, default 24: accumulator width; must be ≥ 17.
- CNT_W, default 8: beat counter and frame length width.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a frame; sampled only in IDLE.
- frame_len, input, CNT_W: number of beats in the frame; latched on start.
- in_valid, input, 1: upstream adder result is valid.
- in_ready, output, 1: block accepts a beat this cycle.
- in_sum, input, 16: adder sum.
- in_cout, input, 1: adder carry-out.
- out_valid, output, 1: frame result is available.
- out_ready, input, 1: downstream takes the result.
- out_acc, output, ACC_W: frame total.
- out_cnt, output, CNT_W: number of beats accumulated.
- out_ovf, output, 1: sticky flag; the accumulator carried out of ACC_W during the frame.
- busy, output, 1: high when the state is not IDLE.

Clocking is fixed: one clock, clk; reset rst_n is asynchronous and active-low.

## Operation
- Operand per beat: opnd = {in_cout, in_sum}, zero-extended to ACC_W.
- A beat is accepted on a cycle where in_valid and in_ready are both high.
- State machine: IDLE, ACC, DONE.

IDLE:
- in_ready = 0 and out_valid = 0.
- When start = 1: latch frame_len into len_q and clear acc, cnt and ovf.
  - If frame_len ≠ 0, go to ACC.
  - If frame_len = 0, go directly to DONE with a zero result.

ACC:
- in_ready = 1.
- On each accepted beat:
  - Compute tmp = acc + opnd at ACC_W+1 bits.
  - If tmp[ACC_W] is set, set ovf to 1. ovf is sticky for the rest of the frame.
  - acc updates as described under Configuration.
  - cnt increments by 1.
- On the beat where cnt = len_q − 1, go to DONE.
- start is ignored in this state.

DONE:
- out_valid = 1; in_ready = 0.
- out_acc, out_cnt and out_ovf are driven from registers and stay stable while out_valid is high.
- When out_ready = 1, go to IDLE. out_valid is low on the next cycle.
- start is ignored in this state.

Other rules:
- out_acc, out_cnt and out_ovf keep their last frame's values in IDLE until the next start clears them.
- in_ready and out_valid are never high in the same cycle.

## Timing
- Reset values:
  - State is IDLE.
  - acc, cnt, len_q and ovf are 0.
  - Outputs are all 0: in_ready = 0, out_valid = 0, out_acc = 0, out_cnt = 0, out_ovf = 0, busy = 0.
- start is sampled at edge T; in_ready and busy are high from T+1.
- Throughput is one beat per cycle. An N-beat frame with in_valid held high accepts beats on N consecutive cycles.
- out_valid rises on the cycle after the last accepting edge.
- Best-case turnaround is start → DONE → IDLE, with the next start accepted 1 cycle after the out_ready handshake.
- Upstream may hold in_valid high in any state; no beat is consumed unless in_ready is high.
- Reset asserted mid-frame forces IDLE immediately. The partial frame is discarded and no out_valid is produced.
- All outputs are registered or decoded from state. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: SUM_ACCUM16_SAT_EN.
- Defined: on overflow, acc is clamped to all-ones (2^ACC_W − 1) and stays there for the rest of the frame. ovf is still set.
- Undefined: acc = tmp[ACC_W-1:0], i.e. it wraps modulo 2^ACC_W. ovf is set.
- The handshake and all cycle timing are identical in both builds.

## Test plan
- Basic frame: frame_len = 3; beats {0,FFFF}, {1,0000}, {0,0001} on back-to-back cycles → out_acc = 0x020000, out_cnt = 3, out_ovf = 0; out_valid rises 1 cycle after the third accept.
- Overflow: ACC_W = 24; frame_len = 129; every beat is {1,FFFF} → out_ovf = 1.
  - Without the macro: out_acc = 0x01FF7F.
  - With SUM_ACCUM16_SAT_EN: out_acc = 0xFFFFFF.
- Back-pressure:
  - Upstream: in_valid toggles every other cycle. Sum of 4 beats of 0x0010 gives out_acc = 0x40.
  - Downstream: out_ready held low for 5 cycles. Outputs stay stable and in_ready stays 0 for the whole hold; out_valid falls 1 cycle after out_ready goes high.
- Zero length: start with frame_len = 0 → out_valid = 1 on the next cycle with out_acc = 0, out_cnt = 0, out_ovf = 0. No beat is accepted.
- Reset mid-frame: drop rst_n after 2 of 5 beats → state is IDLE immediately and all outputs are 0. A new 1-beat frame of 0x0005 then produces out_acc = 5.
- Ignored start: pulse start during ACC and during DONE → frame length and result are unaffected, and no extra frame is produced.
